// File: rtl/event_q_ctrl_pkg.sv
// Shared event widths, heap capacity and controller enums for event_q_ctrl.
package event_q_ctrl_pkg;

  localparam int EQ_DW  = 32;               // event width
  localparam int EQ_CW  = EQ_DW;            // timestamp bits used for ordering
  localparam int EQ_HD  = 5;                // heap depth
  localparam int EQ_CAP = (1 << EQ_HD) - 1; // heap capacity in events
  localparam int TS_LSB = 0;                // timestamp field starts at bit 0

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SETTLE = 1'b1
  } ctrl_state_e;

  typedef enum logic {
    OP_ENQ = 1'b0,
    OP_DEQ = 1'b1
  } heap_op_e;

endpackage

// File: rtl/event_q_ctrl_arb.sv
// Round-robin arbiter: grants the first requester after the last granted port.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    for (int off = 1; off <= N; off++) begin
      idx = PW'((int'(ptr_q) + off) % N);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        if (adv_i) ptr_d = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PW'(N - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/event_q_ctrl.sv
// Request-side controller for prio_q: arbitrates producers, paces enq/deq, stages the root.
// Optional statistics outputs are built when EQ_STATS_EN is defined.
module event_q_ctrl
  import event_q_ctrl_pkg::*;
#(
  parameter int DW     = EQ_DW,
  parameter int CW     = EQ_CW,
  parameter int HD     = EQ_HD,
  parameter int NPROD  = 4,
  parameter int SETTLE = 1
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic [NPROD-1:0]    in_valid,
  input  logic [NPROD*DW-1:0] in_data,
  output logic [NPROD-1:0]    in_ready,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  input  logic                out_ready,
  output logic                hq_enq,
  output logic                hq_deq,
  output logic [DW-1:0]       hq_inp_data,
  input  logic [DW-1:0]       hq_out_data,
  input  logic [HD-1:0]       hq_count,
`ifdef EQ_STATS_EN
  output logic [31:0]         stat_enq,
  output logic [31:0]         stat_deq,
  output logic [HD-1:0]       stat_maxocc,
`endif
  output logic                order_err
);

  localparam int            SCW  = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [HD-1:0] FULL = '1;

  ctrl_state_e   state_q, state_d;
  logic [SCW-1:0] settle_q, settle_d;
  heap_op_e      last_op_q, last_op_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [CW-1:0] last_ts_q, last_ts_d;
  logic          order_err_q, order_err_d;

  logic             run, slot_free, deq_ok, enq_ok, do_deq, do_enq;
  logic [NPROD-1:0] arb_req, arb_gnt;
  logic [DW-1:0]    sel_data;

  // Strobes are qualified with rst_n so every output is quiet while reset is held.
  always_comb begin
    run       = rst_n && (state_q == ST_RUN);
    slot_free = !out_valid_q || out_ready;
    deq_ok    = run && (hq_count != '0) && slot_free;
    enq_ok    = run && (hq_count != FULL) && (|in_valid);
    do_deq    = deq_ok && (!enq_ok || (last_op_q == OP_ENQ));
    do_enq    = enq_ok && !do_deq;
    arb_req   = do_enq ? in_valid : '0;
  end

  rr_arbiter #(.N(NPROD)) u_arb (
    .clk   (CLK),
    .rst_n (rst_n),
    .req_i (arb_req),
    .adv_i (do_enq),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NPROD; i++)
      if (arb_gnt[i]) sel_data = in_data[i*DW +: DW];
  end

  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d     = state_q;
    settle_d    = settle_q;
    last_op_d   = last_op_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    last_ts_d   = last_ts_q;
    order_err_d = order_err_q;

    unique case (state_q)
      ST_RUN: begin
        if (do_deq && (SETTLE > 0)) begin
          state_d  = ST_SETTLE;
          settle_d = SCW'(SETTLE);
        end
      end
      ST_SETTLE: begin
        settle_d = settle_q - 1'b1;
        if (settle_d == '0) state_d = ST_RUN;
      end
    endcase

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (do_deq) begin
      out_valid_d = 1'b1;
      out_data_d  = hq_out_data;
      last_ts_d   = hq_out_data[TS_LSB +: CW];
      last_op_d   = OP_DEQ;
    end

    if (do_enq) begin
      last_op_d = OP_ENQ;
      if (sel_data[TS_LSB +: CW] < last_ts_q) order_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      settle_q    <= '0;
      last_op_q   <= OP_DEQ;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      last_ts_q   <= '0;
      order_err_q <= 1'b0;
    end else begin
      // NOTE: registered state is updated with non-blocking assignments only.
      state_q     <= state_d;
      settle_q    <= settle_d;
      last_op_q   <= last_op_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      last_ts_q   <= last_ts_d;
      order_err_q <= order_err_d;
    end
  end

  assign in_ready    = arb_gnt;
  assign hq_enq      = do_enq;
  assign hq_deq      = do_deq;
  assign hq_inp_data = sel_data;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign order_err   = order_err_q;

`ifdef EQ_STATS_EN
  logic [31:0]   stat_enq_q, stat_deq_q;
  logic [HD-1:0] stat_maxocc_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      stat_enq_q    <= '0;
      stat_deq_q    <= '0;
      stat_maxocc_q <= '0;
    end else begin
      stat_enq_q <= stat_enq_q + {31'b0, do_enq};
      stat_deq_q <= stat_deq_q + {31'b0, do_deq};
      if (hq_count > stat_maxocc_q) stat_maxocc_q <= hq_count;
    end
  end

  assign stat_enq    = stat_enq_q;
  assign stat_deq    = stat_deq_q;
  assign stat_maxocc = stat_maxocc_q;
`endif

endmodule

// File: tb/tb_event_q_ctrl.sv
// Directed bench for event_q_ctrl with a sorted-array stand-in for prio_q.
module tb_event_q_ctrl;
  import event_q_ctrl_pkg::*;

  localparam int DW    = EQ_DW;
  localparam int HD    = EQ_HD;
  localparam int CAP   = EQ_CAP;
  localparam int NPROD = 4;

  logic              CLK;
  logic              rst_n;
  logic [NPROD-1:0]  in_valid;
  logic [NPROD*DW-1:0] in_data;
  logic [NPROD-1:0]  in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_ready;
  logic              hq_enq, hq_deq;
  logic [DW-1:0]     hq_inp_data, hq_out_data;
  logic [HD-1:0]     hq_count;
  logic              order_err;
`ifdef EQ_STATS_EN
  logic [31:0]       stat_enq, stat_deq;
  logic [HD-1:0]     stat_maxocc;
`endif

  event_q_ctrl #(.DW(DW), .CW(DW), .HD(HD), .NPROD(NPROD), .SETTLE(1)) dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .hq_enq      (hq_enq),
    .hq_deq      (hq_deq),
    .hq_inp_data (hq_inp_data),
    .hq_out_data (hq_out_data),
    .hq_count    (hq_count),
`ifdef EQ_STATS_EN
    .stat_enq    (stat_enq),
    .stat_deq    (stat_deq),
    .stat_maxocc (stat_maxocc),
`endif
    .order_err   (order_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- prio_q stand-in: ascending sorted array ----------------
  typedef logic [CAP-1:0][DW-1:0] heap_t;
  heap_t hm;
  int    hn;
  int    deq_total = 0;
  logic  both_seen = 1'b0;
  logic  proto_bad = 1'b0;

  function automatic heap_t heap_ins(input heap_t h, input int n, input logic [DW-1:0] v);
    heap_t r = h;
    int    p = n;
    for (int i = n - 1; i >= 0; i--) if (h[i] > v) p = i;
    for (int i = CAP - 1; i > 0; i--) if (i > p) r[i] = h[i-1];
    if (p < CAP) r[p] = v;
    return r;
  endfunction

  function automatic heap_t heap_del(input heap_t h);
    heap_t r = h;
    for (int i = 0; i < CAP - 1; i++) r[i] = h[i+1];
    r[CAP-1] = '0;
    return r;
  endfunction

  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      hm <= '0;
      hn <= 0;
    end else if (hq_enq && hn < CAP) begin
      hm <= heap_ins(hm, hn, hq_inp_data);
      hn <= hn + 1;
    end else if (hq_deq && hn > 0) begin
      hm <= heap_del(hm);
      hn <= hn - 1;
    end
  end

  always @(posedge CLK) begin
    if (rst_n) begin
      if (hq_enq && hq_deq)        both_seen <= 1'b1;
      if (hq_enq && hn >= CAP)     proto_bad <= 1'b1;
      if (hq_deq && hn == 0)       proto_bad <= 1'b1;
      if (hq_deq)                  deq_total <= deq_total + 1;
    end
  end

  assign hq_out_data = hm[0];
  assign hq_count    = HD'(hn);

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [NPROD*DW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic                pre_rst;
    logic [NPROD-1:0]    vld;
    logic [NPROD*DW-1:0] data;
    logic                ordy;
    logic [NPROD-1:0]    x_rdy;
    logic                x_enq;
    logic                x_deq;
    logic [DW-1:0]       x_inp;
    logic                x_ov;
    logic [DW-1:0]       x_od;
    logic                x_err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input int pr, input int v, input int d0, input int d1,
                              input int d2, input int d3, input int ordy, input int rdy,
                              input int enq, input int deq, input int inp, input int ov,
                              input int od, input int err);
    vec_t r;
    r.pre_rst = 1'(pr);
    r.vld     = 4'(v);
    r.data    = pack4(d0, d1, d2, d3);
    r.ordy    = 1'(ordy);
    r.x_rdy   = 4'(rdy);
    r.x_enq   = 1'(enq);
    r.x_deq   = 1'(deq);
    r.x_inp   = DW'(inp);
    r.x_ov    = 1'(ov);
    r.x_od    = DW'(od);
    r.x_err   = 1'(err);
    return r;
  endfunction

  logic [DW-1:0] pd [NPROD];
  logic [1:0]    gseq [5];
  int            seq, n_grants, onehot_bad, upd, d_before;

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) gseq[i] = '0;

    //           pr vld   d0  d1 d2 d3 ordy rdy  enq deq inp ov od  err
    // single event latency: enq at 0, deq at 1, out_valid at 2
    vt.push_back(mk(1, 'h1,  5, 0, 0, 0, 1, 'h1, 1, 0, 5,  0, 0,  0));
    vt.push_back(mk(0, 'h0,  0, 0, 0, 0, 1, 'h0, 0, 1, 0,  0, 0,  0));
    vt.push_back(mk(0, 'h0,  0, 0, 0, 0, 1, 'h0, 0, 0, 0,  1, 5,  0));
    vt.push_back(mk(0, 'h0,  0, 0, 0, 0, 1, 'h0, 0, 0, 0,  0, 5,  0));
    // slot pre-filled with ts 1, then 9/3/7 queue up behind it and drain in order
    vt.push_back(mk(1, 'h8,  0, 0, 0, 1, 0, 'h8, 1, 0, 1,  0, 0,  0));
    vt.push_back(mk(0, 'h0,  0, 0, 0, 0, 0, 'h0, 0, 1, 0,  0, 0,  0));
    vt.push_back(mk(0, 'h1,  9, 0, 0, 0, 0, 'h0, 0, 0, 0,  1, 1,  0));
    vt.push_back(mk(0, 'h1,  9, 0, 0, 0, 0, 'h1, 1, 0, 9,  1, 1,  0));
    vt.push_back(mk(0, 'h2,  0, 3, 0, 0, 0, 'h2, 1, 0, 3,  1, 1,  0));
    vt.push_back(mk(0, 'h4,  0, 0, 7, 0, 0, 'h4, 1, 0, 7,  1, 1,  0));
    vt.push_back(mk(0, 'h0,  0, 0, 0, 0, 1, 'h0, 0, 1, 0,  1, 1,  0));
    vt.push_back(mk(0, 'h0,  0, 0, 0, 0, 1, 'h0, 0, 0, 0,  1, 3,  0));
    vt.push_back(mk(0, 'h0,  0, 0, 0, 0, 1, 'h0, 0, 1, 0,  0, 3,  0));
    vt.push_back(mk(0, 'h0,  0, 0, 0, 0, 1, 'h0, 0, 0, 0,  1, 7,  0));
    vt.push_back(mk(0, 'h0,  0, 0, 0, 0, 1, 'h0, 0, 1, 0,  0, 7,  0));
    vt.push_back(mk(0, 'h0,  0, 0, 0, 0, 1, 'h0, 0, 0, 0,  1, 9,  0));
    vt.push_back(mk(0, 'h0,  0, 0, 0, 0, 1, 'h0, 0, 0, 0,  0, 9,  0));
    // causality: ts 20 dequeued, later ts 12 enqueued -> sticky order_err, 12 still delivered
    vt.push_back(mk(1, 'h1, 20, 0, 0, 0, 1, 'h1, 1, 0, 20, 0, 0,  0));
    vt.push_back(mk(0, 'h0,  0, 0, 0, 0, 1, 'h0, 0, 1, 0,  0, 0,  0));
    vt.push_back(mk(0, 'h2,  0, 12, 0, 0, 1, 'h0, 0, 0, 0, 1, 20, 0));
    vt.push_back(mk(0, 'h2,  0, 12, 0, 0, 1, 'h2, 1, 0, 12, 0, 20, 0));
    vt.push_back(mk(0, 'h0,  0, 0, 0, 0, 1, 'h0, 0, 1, 0,  0, 20, 1));
    vt.push_back(mk(0, 'h0,  0, 0, 0, 0, 1, 'h0, 0, 0, 0,  1, 12, 1));
    vt.push_back(mk(0, 'h0,  0, 0, 0, 0, 1, 'h0, 0, 0, 0,  0, 12, 1));

    // reset state
    repeat (2) @(negedge CLK);
    #1;
    check("reset_state", {in_ready, out_valid, out_data, hq_enq, hq_deq, hq_inp_data, order_err}, '0);
    rst_n = 1'b1;

    for (int k = 0; k < vt.size(); k++) begin
      if (vt[k].pre_rst) do_reset();
      @(negedge CLK);
      in_valid  = vt[k].vld;
      in_data   = vt[k].data;
      out_ready = vt[k].ordy;
      #2;
      check($sformatf("vec%0d", k),
            {in_ready, hq_enq, hq_deq, hq_inp_data, out_valid, out_data, order_err},
            {vt[k].x_rdy, vt[k].x_enq, vt[k].x_deq, vt[k].x_inp, vt[k].x_ov, vt[k].x_od, vt[k].x_err});
    end

    // all ports busy, slot never drained: grants rotate and the heap fills
    do_reset();
    for (int i = 0; i < NPROD; i++) pd[i] = DW'(100 + i);
    seq        = 104;
    n_grants   = 0;
    onehot_bad = 0;
    @(negedge CLK);
    in_valid  = '1;
    out_ready = 1'b0;
    in_data   = {pd[3], pd[2], pd[1], pd[0]};
    for (int c = 0; c < 60; c++) begin
      #2;
      upd = -1;
      if ((in_ready & (in_ready - 4'd1)) != 4'd0) onehot_bad++;
      if (hq_enq) begin
        for (int i = 0; i < NPROD; i++) if (in_ready[i]) upd = i;
        if (n_grants < 5 && upd >= 0) gseq[n_grants] = 2'(upd);
        n_grants++;
      end
      @(negedge CLK);
      if (upd >= 0) begin
        pd[upd] = DW'(seq);
        seq++;
      end
      in_data = {pd[3], pd[2], pd[1], pd[0]};
    end
    #2;
    check("grant_order", {gseq[0], gseq[1], gseq[2], gseq[3], gseq[4]}, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0});
    check("enq_count", n_grants, 32);
    check("full_count", hq_count, 31);
    check("full_ready", in_ready, 0);
    check("full_stage", {out_valid, out_data}, {1'b1, DW'(100)});
    check("onehot", onehot_bad, 0);

    // full heap, single out_ready pulse: one deq, idle, then one enq
    d_before = deq_total;
    @(negedge CLK);
    out_ready = 1'b1;
    #2;
    check("full_pulse_deq", {hq_deq, hq_enq, in_ready}, {1'b1, 1'b0, 4'h0});
    @(negedge CLK);
    out_ready = 1'b0;
    #2;
    check("full_settle", {hq_deq, hq_enq, out_valid, out_data}, {1'b0, 1'b0, 1'b1, DW'(101)});
    @(negedge CLK);
    #2;
    check("full_refill", {hq_enq, hq_deq, in_ready}, {1'b1, 1'b0, 4'h1});
    @(negedge CLK);
    #2;
    check("full_again", {hq_count, in_ready, hq_deq}, {5'd31, 4'h0, 1'b0});
    check("one_deq", deq_total - d_before, 1);

    // reset while the slot is full and the controller is settling
    do_reset();
    @(negedge CLK);
    in_valid  = 4'h1;
    in_data   = pack4(5, 0, 0, 0);
    out_ready = 1'b0;
    #2;
    check("rm_enq", {hq_enq, in_ready}, {1'b1, 4'h1});
    @(negedge CLK);
    in_valid = '0;
    #2;
    check("rm_deq", hq_deq, 1);
    @(negedge CLK);
    #2;
    check("rm_settle", {out_valid, out_data, hq_enq, hq_deq}, {1'b1, DW'(5), 2'b00});
    rst_n = 1'b0;
    #1;
    check("rm_reset", {in_ready, out_valid, out_data, hq_enq, hq_deq, hq_inp_data, order_err}, '0);
    @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
    in_valid  = 4'h1;
    in_data   = pack4(8, 0, 0, 0);
    out_ready = 1'b1;
    #2;
    check("post_enq", {hq_enq, hq_inp_data}, {1'b1, DW'(8)});
    @(negedge CLK);
    in_valid = '0;
    #2;
    check("post_deq", hq_deq, 1);
    @(negedge CLK);
    #2;
    check("post_out", {out_valid, out_data}, {1'b1, DW'(8)});

    check("heap_protocol", {both_seen, proto_bad}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/event_q_ctrl.md
# event_q_ctrl

Request-side controller for the per-LP heap priority queue (`prio_q`). It accepts new events from NPROD producer ports over valid/ready and drives the queue's `enq`/`deq` strobes within the heap's pipeline-spacing rules. It stages the minimum-timestamp event in a one-entry output register for the event dispatcher. It sits between the core-side event generators and `prio_q` on the same clock.

## Interface
- `DW`, default `DW` from global_params, event width; the timestamp occupies bits [CW-1:0].
- `CW`, default `DW`, number of low bits used for timestamp ordering checks.
- `HD`, default 5, heap depth; the queue holds CAP = 2^HD − 1 = 31 events.
- `NPROD`, default 4, number of producer ports.
- `SETTLE`, default 1, idle cycles required after any deq before the next heap operation.
- `CLK`, in, 1, single clock; all state is updated on the rising edge.
- `rst_n`, in, 1, reset, asynchronous and active-low.
- `in_valid`, in, NPROD, per-producer event valid.
- `in_data`, in, NPROD*DW, producer events; port i occupies [i*DW +: DW].
- `in_ready`, out, NPROD, one-hot grant (at most one bit set); combinational from registered state and `in_valid`.
- `out_valid`, out, 1, staged event valid.
- `out_data`, out, DW, staged event (registered).
- `out_ready`, in, 1, dispatcher accepts the staged event.
- `hq_enq`, out, 1, drives `prio_q.enq`.
- `hq_deq`, out, 1, drives `prio_q.deq`.
- `hq_inp_data`, out, DW, drives `prio_q.inp_data`.
- `hq_out_data`, in, DW, from `prio_q.out_data`; the current root.
- `hq_count`, in, HD, from `prio_q.count`.
- `order_err`, out, 1, sticky causality-violation flag.

## Operation
- Controller state machine has two states, RUN and SETTLE.
  - RUN: at most one heap operation per cycle; `hq_enq` and `hq_deq` are never both 1.
  - Issuing a deq moves RUN → SETTLE and loads a settle counter with SETTLE.
  - In SETTLE, neither `hq_enq` nor `hq_deq` is asserted.
  - The counter decrements each cycle; SETTLE → RUN when it reaches 0 (with SETTLE=1 there is exactly one idle cycle).
- Deq is eligible when all of the following hold: state is RUN, `hq_count` ≠ 0, and the output slot is free (`!out_valid`, or `out_valid && out_ready` in this cycle).
- Enq is eligible when all of the following hold: state is RUN, `hq_count` < CAP, and some `in_valid` bit is set.
- When both are eligible, the operation is chosen by a `last_op` toggle: the operation not issued most recently wins. This prevents either side from starving.
- Enq:
  - A round-robin arbiter picks the first requesting port after the last granted port.
  - The granted port gets `in_ready`=1; `hq_inp_data` = that port's data.
  - `hq_enq`=1 in the same cycle.
  - The grant pointer advances only on a completed handshake.
- Deq:
  - `hq_deq`=1.
  - `out_data` ← `hq_out_data` (the root before the deq) at the same edge.
  - `out_valid` ← 1.
- Output slot:
  - `out_valid` clears on `out_valid && out_ready` unless it is refilled in the same cycle.
  - `out_data` is held stable while `out_valid && !out_ready`.
- Causality:
  - `last_ts` records the timestamp of each dequeued event.
  - An accepted enq with `in_data[CW-1:0]` < `last_ts` sets `order_err`.
  - `order_err` is cleared only by reset; the event is still enqueued.
- Full (`hq_count`=31): all `in_ready` are 0 and deq proceeds normally.
- Empty (`hq_count`=0): no deq is issued and `out_valid` drains to 0.

## Timing
- Reset values:
  - `in_ready`=0, `out_valid`=0, `out_data`=0.
  - `hq_enq`=0, `hq_deq`=0, `hq_inp_data`=0.
  - `order_err`=0.
  - Internal: state=RUN, grant pointer=NPROD−1, `last_op`=deq, `last_ts`=0.
- Reset asserted mid-operation clears the staged event and state immediately. `prio_q` is reset from the same `rst_n`, so the two stay consistent.
- Latency from enq to `out_valid`:
  - Enq accepted at cycle 0 into an empty queue.
  - Deq issued at cycle 1.
  - `out_valid`=1 at cycle 2.
- Throughput:
  - With SETTLE=1, a deq can be issued at most every 2 cycles.
  - Enqueues can be accepted every cycle while no deq is pending.
- `hq_count` is sampled in the cycle of issue; the controller relies on `prio_q` updating `count` at the same edge.

## Configuration
- `EQ_STATS_EN` defined: adds the following outputs:
  - `stat_enq`, 32 bits, counts accepted enqueues.
  - `stat_deq`, 32 bits, counts issued dequeues.
  - `stat_maxocc`, HD bits, the maximum `hq_count` seen.
  - All three reset to 0; the 32-bit counters wrap modulo 2^32.
- `EQ_STATS_EN` undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- `DW`, `CW` and `HD` come from global_params.
- The event timestamp field slice and CAP belong in the shared package alongside them.
- One sub-module: `rr_arbiter`, parameterised on NPROD.
  - Inputs: request vector, advance strobe.
  - Output: one-hot grant.
  - Internal: pointer register on `CLK`/`rst_n`.

## Test plan
- Single producer enqueues ts=5, `out_ready`=1 → `hq_enq` at cycle 0, `hq_deq` at cycle 1, `out_valid` with ts=5 at cycle 2.
- Port 0 enqueues ts 9, then port 1 ts 3, then port 2 ts 7; `out_ready` is held 0 until all three are in, then held 1 → outputs 3, 7, 9, with ≥1 idle heap cycle between deqs.
- All 4 ports are valid continuously, `out_ready`=0 → grants rotate 0,1,2,3,0; after 31 enqueues plus 1 staged event, `in_ready`=0 while `hq_count`=31.
- Heap full, then `out_ready` pulsed → exactly one deq is issued and an enq is accepted in the next RUN cycle.
- Dequeue ts=20, then enqueue ts=12 → `order_err` rises the next cycle and stays 1; ts=12 is still dequeued later.
- Reset asserted while `out_valid`=1 and state is SETTLE → all outputs are 0 immediately; the first enq after release completes with the 2-cycle latency.
